apb_uart_fifo_ctrl: RTL and testbench
=====================================

Name: apb_uart_fifo_ctrl

Overview:
APB3 register/buffer front end for the UART serial engine, parametrised in character width and FIFO depth. Holds a TX FIFO feeding the engine through a valid/ready handshake and an RX FIFO filled by the engine. Each RX entry stores its parity and framing error flags alongside the data. Adds programmable level thresholds, sticky overflow flags and a maskable registered interrupt, so firmware can run interrupt-driven.

Parameters:
DATA_W, 8, character width; legal range 5..9.
DEPTH, 16, entries per FIFO; power of 2, 2..128.
TIMEOUT_CYC, 1024, PCLK cycles of RX idle before the timeout flag sets (optional feature only).

Ports:
PCLK  in  1  APB clock; all logic is on its rising edge.
aresetn  in  1  reset, asynchronous, active-low.
PADDR  in  5  byte address; PADDR[4:2] selects one of 8 word registers.
PSEL  in  1  APB select.
PENABLE  in  1  APB access phase.
PWRITE  in  1  1 = write.
PWDATA  in  16  write data.
PRDATA  out  16  read data.
PREADY  out  1  tied 1 (no wait states).
PSLVERR  out  1  tied 0.
tx_data  out  DATA_W  TX FIFO head (first-word fall-through).
tx_valid  out  1  high while the TX FIFO is not empty.
tx_ready  in  1  engine accepts tx_data when tx_valid && tx_ready.
rx_data  in  DATA_W  received character.
rx_err  in  2  {framing, parity} error for rx_data.
rx_valid  in  1  one-cycle push strobe from the engine.
IRQ  out  1  registered interrupt request.

Behaviour:
- APB access = PSEL && PENABLE.
- PRDATA is combinational during a read access and 0 otherwise. Unused bits read 0.
- Register map (PADDR[4:2]):
  - 0 TXDATA, W: pushes PWDATA[DATA_W-1:0]. Reads 0.
  - 1 RXDATA, R: returns {rx_err, data} of the RX head; the read access pops the head. A read when empty returns 0 and nothing changes.
  - 2 STATUS, R: bit0 tx_empty, 1 tx_full, 2 rx_empty, 3 rx_full.
  - 3 LEVEL, R: {rx_count[7:0], tx_count[7:0]}.
  - 4 CTRL, R/W: [7:0] rx_thresh, [15:8] tx_thresh. Reset 0x0001.
  - 5 IRQ_EN, R/W: [4:0]. Reset 0.
  - 6 IRQ_STAT, R, write-1-to-clear on sticky bits.
  - 7 FLUSH, W: bit0 clears TX FIFO, bit1 clears RX FIFO. Reads 0.
- Counts are $clog2(DEPTH)+1 bits wide. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- TX FIFO:
  - Push on a TXDATA write when not full.
  - Pop when tx_valid && tx_ready.
  - Push and pop in the same cycle while full: both succeed, count unchanged.
  - Write while full with no pop in that cycle: data dropped, IRQ_STAT[3] TX_OVF set.
- RX FIFO:
  - Push on rx_valid when not full, or when full with a same-cycle RXDATA pop.
  - Otherwise the push is dropped and IRQ_STAT[2] RX_OVF is set.
- Flush takes priority over a push or pop in the same cycle on the same FIFO. Flush does not clear the overflow flags.
- IRQ_STAT bits:
  - 0 RX_LVL, level: rx_thresh != 0 && rx_count >= rx_thresh.
  - 1 TX_LVL, level: tx_count <= tx_thresh.
  - 2 RX_OVF, sticky.
  - 3 TX_OVF, sticky.
  - 4 RX_TO, sticky.
  - Level bits ignore W1C.
  - A set event in the same cycle as its W1C: the set wins.
- IRQ <= |(IRQ_STAT & IRQ_EN), registered: asserts 1 cycle after the cause becomes visible.
- Reset values: FIFOs empty, tx_valid 0, tx_data 0, IRQ 0, all sticky flags 0.
- Reset mid-transfer discards all FIFO contents immediately.
- The engine must not depend on tx_data while tx_valid is 0.

Optional Feature:
- Macro: APB_UART_RX_TIMEOUT_EN.
- Defined:
  - Counter of width $clog2(TIMEOUT_CYC)+1 increments each cycle while the RX FIFO is non-empty with no push or pop.
  - It clears on any push, pop, RX flush, or when the FIFO is empty.
  - On reaching TIMEOUT_CYC it sets IRQ_STAT[4] once, then holds until the next clear.
- Undefined: no counter is built; IRQ_STAT[4] and IRQ_EN[4] read 0 and ignore writes.

Test Plan:
- Reset, then read STATUS and LEVEL -> STATUS=0x0005, LEVEL=0x0000, IRQ=0, tx_valid=0.
- Write 0x41, 0x42, 0x43 to TXDATA with tx_ready=0 -> LEVEL=0x0003, tx_data=0x41. Raise tx_ready for 3 cycles -> engine sees 0x41, 0x42, 0x43, then tx_valid=0, IRQ_STAT[1]=1.
- DEPTH=16: write 17 characters with tx_ready=0 -> STATUS[1]=1, IRQ_STAT[3]=1, 17th dropped. Write IRQ_STAT=0x08 -> bit3 clears.
- CTRL=0x0004, IRQ_EN=0x01; push 4 characters with rx_err=2'b01 on the last -> IRQ high 1 cycle after the 4th push. 4th RXDATA read returns 0x1xx (parity bit set); IRQ drops after the first read.
- Full RX FIFO, rx_valid coincident with an RXDATA read -> no overflow, count stays 16, new data at the tail.
- With APB_UART_RX_TIMEOUT_EN, TIMEOUT_CYC=8: push 1 character, then idle -> IRQ_STAT[4] sets after exactly 8 idle cycles. Same run without the macro -> IRQ_STAT[4] stays 0.

Source files
------------

// File: rtl/apb_uart_fifo_ctrl.sv
// APB3 register front end for the UART engine: TX/RX FIFOs, level thresholds, sticky flags, IRQ.
// Optional RX idle timeout flag is built only when APB_UART_RX_TIMEOUT_EN is defined.
module apb_uart_fifo_ctrl #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              PCLK,
  input  logic              aresetn,
  input  logic [4:0]        PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [15:0]       PWDATA,
  output logic [15:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [1:0]        rx_err,
  input  logic              rx_valid,
  output logic              IRQ
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = DATA_W + 2;
`ifdef APB_UART_RX_TIMEOUT_EN
  localparam logic [4:0] IRQ_EN_MASK = 5'h1f;
`else
  localparam logic [4:0] IRQ_EN_MASK = 5'h0f;
`endif

  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [RW-1:0]     rx_mem [DEPTH];

  logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CW-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic [15:0]   ctrl_q, ctrl_d;
  logic [4:0]    irq_en_q, irq_en_d;
  logic [2:0]    sticky_q, sticky_d;
  logic          irq_q, irq_d;

  logic       acc, wr_acc, rd_acc;
  logic [2:0] reg_sel;
  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic       tx_wr, tx_push, tx_pop, tx_ovf_set, flush_tx;
  logic       rx_push, rx_pop, rx_ovf_set, flush_rx;
  logic       tx_lvl, rx_lvl, to_set;
  logic [2:0] w1c;
  logic [4:0] irq_stat;
  logic [15:0] prdata;
  logic       unused_bits;

  assign acc     = PSEL && PENABLE;
  assign wr_acc  = acc && PWRITE;
  assign rd_acc  = acc && !PWRITE;
  assign reg_sel = PADDR[4:2];
  assign unused_bits = &{1'b0, PADDR[1:0]};

  assign tx_empty = (tx_count_q == '0);
  assign tx_full  = (tx_count_q == CW'(DEPTH));
  assign rx_empty = (rx_count_q == '0);
  assign rx_full  = (rx_count_q == CW'(DEPTH));

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_empty ? '0 : tx_mem[tx_rd_ptr_q];

  assign tx_wr      = wr_acc && (reg_sel == 3'd0);
  assign flush_tx   = wr_acc && (reg_sel == 3'd7) && PWDATA[0];
  assign flush_rx   = wr_acc && (reg_sel == 3'd7) && PWDATA[1];
  assign tx_pop     = !tx_empty && tx_ready;
  assign tx_push    = tx_wr && (!tx_full || tx_pop);
  assign tx_ovf_set = tx_wr && tx_full && !tx_pop;
  assign rx_pop     = rd_acc && (reg_sel == 3'd1) && !rx_empty;
  assign rx_push    = rx_valid && (!rx_full || rx_pop);
  assign rx_ovf_set = rx_valid && !rx_push;

  assign tx_lvl   = (8'(tx_count_q) <= ctrl_q[15:8]);
  assign rx_lvl   = (ctrl_q[7:0] != 8'd0) && (8'(rx_count_q) >= ctrl_q[7:0]);
  assign irq_stat = {sticky_q, tx_lvl, rx_lvl};
  assign w1c      = (wr_acc && (reg_sel == 3'd6)) ? PWDATA[4:2] : 3'b000;

  // Storage has no reset: emptiness is tracked entirely by the counts.
  always_ff @(posedge PCLK) begin
    if (tx_push && !flush_tx) tx_mem[tx_wr_ptr_q] <= PWDATA[DATA_W-1:0];
    if (rx_push && !flush_rx) rx_mem[rx_wr_ptr_q] <= {rx_err, rx_data};
  end

  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_count_d  = tx_count_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_count_d  = rx_count_q;
    if (flush_tx) begin
      tx_wr_ptr_d = '0;
      tx_rd_ptr_d = '0;
      tx_count_d  = '0;
    end else begin
      if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + AW'(1);
      if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count_d = tx_count_q + CW'(1);
        2'b01:   tx_count_d = tx_count_q - CW'(1);
        default: tx_count_d = tx_count_q;
      endcase
    end
    if (flush_rx) begin
      rx_wr_ptr_d = '0;
      rx_rd_ptr_d = '0;
      rx_count_d  = '0;
    end else begin
      if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + AW'(1);
      if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count_d = rx_count_q + CW'(1);
        2'b01:   rx_count_d = rx_count_q - CW'(1);
        default: rx_count_d = rx_count_q;
      endcase
    end
  end

  always_comb begin
    ctrl_d   = (wr_acc && (reg_sel == 3'd4)) ? PWDATA : ctrl_q;
    irq_en_d = (wr_acc && (reg_sel == 3'd5)) ? (PWDATA[4:0] & IRQ_EN_MASK) : irq_en_q;
    // A set event in the same cycle as its clear wins.
    sticky_d = (sticky_q & ~w1c) | {to_set, tx_ovf_set, rx_ovf_set};
    irq_d    = |(irq_stat & irq_en_q);
  end

`ifdef APB_UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_clr;

  assign to_clr = rx_push || rx_pop || flush_rx || rx_empty;

  // Counter saturates at TIMEOUT_CYC so the flag fires once per idle stretch.
  always_comb begin
    to_cnt_d = to_cnt_q;
    to_set   = 1'b0;
    if (to_clr) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TW'(TIMEOUT_CYC)) begin
      to_cnt_d = to_cnt_q + TW'(1);
      to_set   = (to_cnt_q == TW'(TIMEOUT_CYC - 1));
    end
  end

  always_ff @(posedge PCLK or negedge aresetn) begin
    if (!aresetn) to_cnt_q <= '0;
    else          to_cnt_q <= to_cnt_d;
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign to_set = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge aresetn) begin
    if (!aresetn) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      ctrl_q      <= 16'h0001;
      irq_en_q    <= '0;
      sticky_q    <= '0;
      irq_q       <= 1'b0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
      ctrl_q      <= ctrl_d;
      irq_en_q    <= irq_en_d;
      sticky_q    <= sticky_d;
      irq_q       <= irq_d;
    end
  end

  always_comb begin
    prdata = '0;
    if (rd_acc) begin
      case (reg_sel)
        3'd1:    prdata = rx_empty ? 16'h0000 : 16'(rx_mem[rx_rd_ptr_q]);
        3'd2:    prdata = {12'd0, rx_full, rx_empty, tx_full, tx_empty};
        3'd3:    prdata = {8'(rx_count_q), 8'(tx_count_q)};
        3'd4:    prdata = ctrl_q;
        3'd5:    prdata = {11'd0, irq_en_q};
        3'd6:    prdata = {11'd0, irq_stat};
        default: prdata = '0;
      endcase
    end
  end

  assign PRDATA  = prdata;
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign IRQ     = irq_q;
endmodule

// File: tb/tb_apb_uart_fifo_ctrl.sv
// Bench for apb_uart_fifo_ctrl: queue-based reference model compared every cycle, plus directed literal checks.
module tb_apb_uart_fifo_ctrl;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int TO_CYC = 8;
`ifdef APB_UART_RX_TIMEOUT_EN
  localparam bit HAS_TO = 1'b1;
`else
  localparam bit HAS_TO = 1'b0;
`endif

  logic        PCLK = 1'b0;
  logic        aresetn = 1'b0;
  logic [4:0]  PADDR = '0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [15:0] PWDATA = '0;
  logic [15:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic [1:0]  rx_err = '0;
  logic        rx_valid = 1'b0;
  logic        IRQ;

  int errors = 0;
  int checks = 0;

  apb_uart_fifo_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TO_CYC)) dut (
    .PCLK(PCLK), .aresetn(aresetn), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_err(rx_err), .rx_valid(rx_valid), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  // Reference model: FIFOs as queues, flags as plain bits.
  logic [7:0]  m_tx[$];
  logic [9:0]  m_rx[$];
  logic [15:0] m_ctrl;
  logic [4:0]  m_en;
  bit          m_rxovf, m_txovf, m_to, m_irq;
  int          m_idle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] m_stat();
    logic rl, tl;
    rl = (m_ctrl[7:0] != 8'd0) && (m_rx.size() >= int'(m_ctrl[7:0]));
    tl = (m_tx.size() <= int'(m_ctrl[15:8]));
    return {m_to, m_txovf, m_rxovf, tl, rl};
  endfunction

  function automatic logic [15:0] exp_prdata();
    if (!(PSEL && PENABLE && !PWRITE)) return 16'h0000;
    case (PADDR[4:2])
      3'd1: return (m_rx.size() > 0) ? 16'(m_rx[0]) : 16'h0000;
      3'd2: return {12'd0, m_rx.size() == DEPTH, m_rx.size() == 0, m_tx.size() == DEPTH, m_tx.size() == 0};
      3'd3: return {8'(m_rx.size()), 8'(m_tx.size())};
      3'd4: return m_ctrl;
      3'd5: return {11'd0, m_en};
      3'd6: return {11'd0, m_stat()};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    m_tx.delete();
    m_rx.delete();
    m_ctrl = 16'h0001;
    m_en = '0;
    m_rxovf = 0; m_txovf = 0; m_to = 0; m_irq = 0;
    m_idle = 0;
  endtask

  task automatic model_step();
    bit wr, rd, tx_pop, rx_pop, rx_push, txovf_set, rxovf_set, to_set, flush_rx, irq_next;
    int a, txn, rxn;
    logic [4:0] w1c;
    wr = PSEL && PENABLE && PWRITE;
    rd = PSEL && PENABLE && !PWRITE;
    a = int'(PADDR[4:2]);
    irq_next = |(m_stat() & m_en);
    txn = m_tx.size();
    rxn = m_rx.size();
    tx_pop    = (txn > 0) && tx_ready;
    rx_pop    = rd && (a == 1) && (rxn > 0);
    rx_push   = rx_valid && ((rxn < DEPTH) || rx_pop);
    txovf_set = wr && (a == 0) && (txn == DEPTH) && !tx_pop;
    rxovf_set = rx_valid && !rx_push;
    flush_rx  = wr && (a == 7) && PWDATA[1];
    if (wr && (a == 7) && PWDATA[0]) m_tx.delete();
    else begin
      if (tx_pop) void'(m_tx.pop_front());
      if (wr && (a == 0) && !txovf_set) m_tx.push_back(PWDATA[7:0]);
    end
    if (flush_rx) m_rx.delete();
    else begin
      if (rx_pop) void'(m_rx.pop_front());
      if (rx_push) m_rx.push_back({rx_err, rx_data});
    end
    to_set = 0;
    if (HAS_TO) begin
      if (flush_rx || rx_push || rx_pop || rxn == 0) m_idle = 0;
      else if (m_idle < TO_CYC) begin
        m_idle++;
        if (m_idle == TO_CYC) to_set = 1;
      end
    end
    w1c = (wr && a == 6) ? PWDATA[4:0] : 5'd0;
    m_rxovf = (m_rxovf && !w1c[2]) || rxovf_set;
    m_txovf = (m_txovf && !w1c[3]) || txovf_set;
    m_to    = (m_to && !w1c[4]) || to_set;
    if (wr && a == 4) m_ctrl = PWDATA;
    if (wr && a == 5) m_en = PWDATA[4:0] & (HAS_TO ? 5'h1f : 5'h0f);
    m_irq = irq_next;
  endtask

  always @(posedge PCLK) if (aresetn) model_step();

  always @(negedge PCLK) begin
    chk("tx_valid", tx_valid, m_tx.size() > 0);
    if (m_tx.size() > 0) chk("tx_data", tx_data, m_tx[0]);
    chk("irq", IRQ, m_irq);
    chk("prdata", PRDATA, exp_prdata());
    chk("pready_pslverr", {PSLVERR, PREADY}, 2'b01);
  end

  // Bus tasks are entered 1 time unit after a rising edge and leave the same way.
  task automatic apb_write(input logic [2:0] a, input logic [15:0] d);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = {a, 2'b00}; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1;
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [15:0] d);
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = {a, 2'b00};
    @(posedge PCLK); #1;
    PENABLE = 1;
    @(negedge PCLK);
    d = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0;
  endtask

  task automatic tick();
    @(posedge PCLK); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] d;
    logic [7:0] got [3];
    logic [7:0] last;
    int rise, op;

    model_reset();
    repeat (3) @(posedge PCLK);
    #1 aresetn = 1;

    // Reset state
    @(negedge PCLK);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_irq", IRQ, 0);
    tick();
    apb_read(3'd2, d); chk("rst_status", d, 16'h0005);
    apb_read(3'd3, d); chk("rst_level", d, 16'h0000);
    apb_read(3'd6, d); chk("rst_irq_stat", d, 16'h0002);
    apb_read(3'd4, d); chk("rst_ctrl", d, 16'h0001);

    // Three characters out to the engine
    apb_write(3'd0, 16'h0041);
    apb_write(3'd0, 16'h0042);
    apb_write(3'd0, 16'h0043);
    apb_read(3'd3, d); chk("tx3_level", d, 16'h0003);
    @(negedge PCLK); chk("tx3_head", tx_data, 8'h41);
    tick();
    tx_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK); got[i] = tx_data;
      tick();
    end
    tx_ready = 0;
    chk("tx_seq0", got[0], 8'h41);
    chk("tx_seq1", got[1], 8'h42);
    chk("tx_seq2", got[2], 8'h43);
    @(negedge PCLK); chk("tx_drained", tx_valid, 0);
    tick();
    apb_read(3'd6, d); chk("tx_lvl_stat", d, 16'h0002);

    // TX overflow
    for (int i = 0; i < 17; i++) apb_write(3'd0, 16'(8'h60 + i));
    apb_read(3'd2, d); chk("txfull_status", d, 16'h0006);
    apb_read(3'd6, d); chk("txovf_stat", d, 16'h0008);
    apb_read(3'd3, d); chk("txfull_level", d, 16'h0010);
    apb_write(3'd6, 16'h0008);
    apb_read(3'd6, d); chk("txovf_w1c", d, 16'h0000);
    tx_ready = 1;
    last = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge PCLK); last = tx_data;
      tick();
    end
    tx_ready = 0;
    chk("tx_17th_dropped", last, 8'h6f);

    // RX threshold interrupt
    apb_write(3'd4, 16'h0004);
    apb_write(3'd5, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1; rx_data = 8'(8'h10 + i); rx_err = (i == 3) ? 2'b01 : 2'b00;
      tick();
    end
    rx_valid = 0; rx_err = 0;
    @(negedge PCLK); chk("irq_at_4th_push", IRQ, 0);
    tick();
    @(negedge PCLK); chk("irq_after_4th_push", IRQ, 1);
    tick();
    apb_read(3'd1, d); chk("rx_rd0", d, 16'h0010);
    @(negedge PCLK); chk("irq_at_pop", IRQ, 1);
    tick();
    @(negedge PCLK); chk("irq_after_pop", IRQ, 0);
    tick();
    apb_read(3'd1, d); chk("rx_rd1", d, 16'h0011);
    apb_read(3'd1, d); chk("rx_rd2", d, 16'h0012);
    apb_read(3'd1, d); chk("rx_rd3_parity", d, 16'h0113);
    apb_read(3'd1, d); chk("rx_rd_empty", d, 16'h0000);
    apb_write(3'd5, 16'h0000);

    // RX full: overflow, then push coincident with pop
    for (int i = 0; i < 16; i++) begin
      rx_valid = 1; rx_data = 8'(8'h20 + i);
      tick();
    end
    rx_data = 8'h77;
    tick();
    rx_valid = 0;
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = {3'd1, 2'b00};
    tick();
    PENABLE = 1; rx_valid = 1; rx_data = 8'h99;
    @(negedge PCLK); d = PRDATA;
    tick();
    PSEL = 0; PENABLE = 0; rx_valid = 0;
    chk("rxfull_pop_head", d, 16'h0020);
    apb_read(3'd3, d); chk("rxfull_level", d, 16'h1000);
    apb_read(3'd6, d); chk("rxovf_stat", d, 16'h0007);
    for (int i = 0; i < 16; i++) apb_read(3'd1, d);
    chk("rx_tail_new", d, 16'h0099);
    apb_write(3'd6, 16'h001c);
    apb_read(3'd6, d); chk("rx_w1c", d, 16'h0002);

    // RX idle timeout
    apb_write(3'd5, 16'h0010);
    apb_read(3'd5, d); chk("irq_en_to", d, HAS_TO ? 16'h0010 : 16'h0000);
    rx_valid = 1; rx_data = 8'h55;
    tick();
    rx_valid = 0;
    rise = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge PCLK); #1;
      @(negedge PCLK);
      if (IRQ && rise == 0) rise = k;
    end
    tick();
    chk("to_irq_cycle", rise, HAS_TO ? 9 : 0);
    apb_read(3'd6, d); chk("to_stat", d, HAS_TO ? 16'h0012 : 16'h0002);
    apb_write(3'd6, 16'h0010);
    apb_read(3'd6, d); chk("to_held_after_w1c", d, 16'h0002);
    apb_write(3'd7, 16'h0003);
    apb_write(3'd5, 16'h0000);

    // Randomized traffic against the model, with one reset mid-stream
    apb_write(3'd4, {8'($urandom_range(0, 17)), 8'($urandom_range(0, 17))});
    for (int it = 0; it < 1500; it++) begin
      if (it == 700) begin
        aresetn = 0; model_reset();
        tick(); tick();
        aresetn = 1;
      end
      tx_ready = ($urandom_range(0, 7) < ((it < 700) ? 1 : 4));
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data  = 8'($urandom);
      rx_err   = 2'($urandom);
      op = $urandom_range(0, 19);
      if (op < 6)       apb_write(3'd0, 16'($urandom));
      else if (op < 11) apb_read(3'd1, d);
      else if (op < 14) apb_read(3'($urandom_range(0, 7)), d);
      else if (op == 14) apb_write(3'd6, 16'($urandom));
      else if (op == 15) apb_write(3'd7, 16'($urandom_range(1, 3)));
      else if (op == 16) apb_write(3'd4, {8'($urandom_range(0, 17)), 8'($urandom_range(0, 17))});
      else if (op == 17) apb_write(3'd5, 16'($urandom));
      else tick();
    end
    tx_ready = 0; rx_valid = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
